// File: rtl/cfar_channel_scheduler.sv
// Round-robin frame scheduler sharing one CFAR engine between NUM_CH channels.
// Optional DRAIN timeout enabled by defining CFAR_SCHED_TIMEOUT_EN.
//
// state  | meaning
// IDLE   | no frame in flight, arbitrating among ch_req
// START  | one-cycle eng_start pulse, beat counter cleared
// STREAM | granted channel's samples muxed to the engine
// DRAIN  | all beats sent, waiting for eng_done (or timeout)
module cfar_channel_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 64,
  parameter int TIMEOUT   = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          ch_req,
  input  logic [NUM_CH-1:0]          ch_mode,
  input  logic [NUM_CH*DATA_W-1:0]   ch_data,
  input  logic [NUM_CH-1:0]          ch_valid,
  output logic [NUM_CH-1:0]          ch_ready,
  output logic [NUM_CH-1:0]          ch_grant,
  output logic                       eng_start,
  output logic                       eng_mode,
  output logic [DATA_W-1:0]          eng_data,
  output logic                       eng_valid,
  input  logic                       eng_ready,
  input  logic                       eng_done,
  output logic [$clog2(NUM_CH)-1:0]  active_ch,
  output logic                       busy,
  output logic                       sched_err
);

  localparam int          CH_W = $clog2(NUM_CH);
  localparam int          CNT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned N_CH = NUM_CH;

  if (NUM_CH < 2 || NUM_CH > 8 || FRAME_LEN < 2 || TIMEOUT < 1) begin : g_param_check
    $error("cfar_channel_scheduler: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, START, STREAM, DRAIN} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]  beat_cnt;
  logic [CH_W-1:0]   sel_idx, cand;
  logic              sel_found;
  logic              grant_load, frame_end;
  logic              beat, last_beat;
  logic              timeout_hit;
  logic [DATA_W-1:0] ch_data_arr [NUM_CH];

  function automatic logic [CH_W-1:0] wrap_add(input logic [CH_W-1:0] base,
                                               input int unsigned off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N_CH) s = s - N_CH;
    return s[CH_W-1:0];
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) ch_data_arr[i] = ch_data[i*DATA_W +: DATA_W];
  end

  // First requester at or after rr_ptr, wrapping around.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      cand = wrap_add(rr_ptr, i);
      if (!sel_found && ch_req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  assign beat      = (state_q == STREAM) && eng_valid && eng_ready;
  assign last_beat = beat && (beat_cnt == CNT_W'(FRAME_LEN - 1));

`ifdef CFAR_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] drain_cnt;

  // drain_cnt holds (DRAIN cycle number - 1); eng_done in the last cycle wins.
  always_ff @(posedge clk) begin
    if (rst || state_q != DRAIN) drain_cnt <= '0;
    else                         drain_cnt <= drain_cnt + TO_W'(1);
  end

  assign timeout_hit = (state_q == DRAIN) && !eng_done && (drain_cnt == TO_W'(TIMEOUT - 1));
  assign sched_err   = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign sched_err   = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_load = 1'b0;
    frame_end  = 1'b0;
    eng_start  = 1'b0;
    eng_valid  = 1'b0;
    eng_data   = '0;
    ch_ready   = '0;
    busy       = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (|ch_req) begin
          grant_load = 1'b1;
          state_d    = START;
        end
      end
      START: begin
        eng_start = 1'b1;
        state_d   = STREAM;
      end
      STREAM: begin
        eng_data  = ch_data_arr[active_ch];
        eng_valid = ch_valid[active_ch];
        ch_ready  = ch_grant & {NUM_CH{eng_ready}};
        if (last_beat) begin
          state_d   = eng_done ? IDLE : DRAIN;
          frame_end = eng_done;
        end
      end
      DRAIN: begin
        if (eng_done || timeout_hit) begin
          state_d   = IDLE;
          frame_end = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      ch_grant  <= '0;
      active_ch <= '0;
      eng_mode  <= 1'b0;
      beat_cnt  <= '0;
    end else begin
      state_q <= state_d;
      if (grant_load) begin
        ch_grant  <= NUM_CH'(1) << sel_idx;
        active_ch <= sel_idx;
        eng_mode  <= ch_mode[sel_idx];
      end else if (frame_end) begin
        ch_grant <= '0;
        rr_ptr   <= wrap_add(active_ch, 1);
      end
      if (state_q == START) beat_cnt <= '0;
      else if (beat)        beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cfar_channel_scheduler.sv
// Scoreboard bench for cfar_channel_scheduler: per-frame expected samples are
// queued at grant and popped on every engine beat.
module tb_cfar_channel_scheduler;

  localparam int NUM_CH    = 4;
  localparam int DATA_W    = 16;
  localparam int FRAME_LEN = 64;
  localparam int TIMEOUT   = 100;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_CH-1:0]         ch_req, ch_mode, ch_valid, ch_ready, ch_grant;
  logic [NUM_CH*DATA_W-1:0]  ch_data;
  logic                      eng_start, eng_mode, eng_valid, eng_ready, eng_done;
  logic [DATA_W-1:0]         eng_data;
  logic [1:0]                active_ch;
  logic                      busy, sched_err;

  always #5 clk = ~clk;

  cfar_channel_scheduler #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .ch_req(ch_req), .ch_mode(ch_mode), .ch_data(ch_data),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_grant(ch_grant),
    .eng_start(eng_start), .eng_mode(eng_mode), .eng_data(eng_data),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_done(eng_done),
    .active_ch(active_ch), .busy(busy), .sched_err(sched_err)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] sb_q[$];
  int          src_idx[NUM_CH];
  int          src_frm[NUM_CH];
  bit          bp_mode = 1'b0;

  function automatic logic [15:0] sample_val(input int ch, input int frm, input int idx);
    logic [31:0] c, f, x;
    c = ch; f = frm; x = idx;
    return {c[3:0], f[3:0], x[7:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < NUM_CH; c++) begin
      ch_data[c*DATA_W +: DATA_W] = sample_val(c, src_frm[c], src_idx[c]);
      ch_valid[c] = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    eng_ready = bp_mode ? ~eng_ready : 1'b1;
  endtask

  task automatic tick();
    @(negedge clk);
    drive_inputs();
    #1;
  endtask

  // One granted frame. done_delay: cycles after last beat to pulse eng_done
  // (0 = with last beat, <0 = never). early_done/flip_beat are beat numbers.
  task automatic run_frame(input int exp_ch, input logic exp_mode, input int n_beats,
                           input int done_delay, input int early_done,
                           input int flip_beat, input bit drop_req);
    int          beats = 0;
    int          guard = 0;
    logic [15:0] exp_v;
    logic [3:0]  one = 4'b0001;
    tick();
    check_eq("eng_start", eng_start, 1);
    check_eq("grant", ch_grant, one << exp_ch);
    check_eq("active_ch", active_ch, exp_ch);
    check_eq("eng_mode", eng_mode, exp_mode);
    check_eq("start_no_valid", eng_valid, 0);
    if (drop_req) ch_req = '0;
    for (int i = 0; i < FRAME_LEN; i++) sb_q.push_back(sample_val(exp_ch, src_frm[exp_ch], i));
    while (beats < n_beats && guard < 4000) begin
      tick();
      guard++;
      eng_done = 1'b0;
      if (eng_valid && eng_ready) begin
        exp_v = sb_q.pop_front();
        check_eq("eng_data", eng_data, exp_v);
        check_eq("ch_ready", ch_ready, one << exp_ch);
        check_eq("eng_mode_hold", eng_mode, exp_mode);
        src_idx[exp_ch]++;
        beats++;
        if (beats == flip_beat) ch_mode[exp_ch] = ~exp_mode;
        if (beats == early_done) eng_done = 1'b1;
        if (beats == FRAME_LEN && done_delay == 0) eng_done = 1'b1;
      end
    end
    check_eq("beat_count", beats, n_beats);
    if (n_beats < FRAME_LEN) return;
    src_frm[exp_ch]++;
    src_idx[exp_ch] = 0;
    if (done_delay < 0) return;
    for (int d = 1; d <= done_delay; d++) begin
      tick();
      check_eq("drain_quiet", {eng_valid, ch_ready, busy}, 6'b000001);
      if (d == done_delay) eng_done = 1'b1;
    end
    tick();
    eng_done = 1'b0;
    check_eq("grant_clear", ch_grant, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_dly[5] = '{3, 0, 1, 4, 2};
    int err_cnt = 0;
    int busy_low = 0;
    rst = 1'b1; ch_req = '0; ch_mode = '0; ch_valid = '0; ch_data = '0;
    eng_ready = 1'b0; eng_done = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin src_idx[c] = 0; src_frm[c] = 0; end

    repeat (3) tick();
    check_eq("rst_grant", ch_grant, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_start", eng_start, 0);
    check_eq("rst_active", active_ch, 0);
    check_eq("rst_mode", eng_mode, 0);
    check_eq("rst_err", sched_err, 0);
    check_eq("rst_eng", {eng_valid, ch_ready, eng_data}, 0);
    rst = 1'b0;
    tick(); tick();

    // single requester on ch2, done 5 cycles after last beat
    ch_req = 4'b0100;
    run_frame(2, 1'b0, FRAME_LEN, 5, -1, -1, 1'b1);

    // reset after 10 beats of ch3 with everyone requesting
    tick();
    ch_req = 4'b1111; ch_mode = 4'b1000;
    run_frame(3, 1'b1, 10, -1, -1, -1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    check_eq("mid_rst_grant", ch_grant, 0);
    check_eq("mid_rst_active", active_ch, 0);
    check_eq("mid_rst_mode", eng_mode, 0);
    check_eq("mid_rst_busy", {busy, eng_start, sched_err}, 0);
    check_eq("mid_rst_eng", {eng_valid, ch_ready, eng_data}, 0);
    rst = 1'b0; ch_mode = '0;
    sb_q.delete();
    src_idx[3] = 0;

    // fairness: 5 back-to-back frames, one early (ignored) eng_done in frame 1
    for (int f = 0; f < 5; f++)
      run_frame(f % NUM_CH, 1'b0, FRAME_LEN, done_dly[f], (f == 1) ? 20 : -1, -1, f == 4);

    // backpressure: ready toggles, valid random
    bp_mode = 1'b1;
    ch_req = 4'b0001;
    run_frame(0, 1'b0, FRAME_LEN, 2, -1, -1, 1'b1);
    bp_mode = 1'b0;

    // mode latch on ch1, then the next ch1 frame latches the new mode
    ch_req = 4'b0010; ch_mode = 4'b0010;
    run_frame(1, 1'b1, FRAME_LEN, 3, -1, 10, 1'b1);
    ch_req = 4'b0010;
    run_frame(1, 1'b0, FRAME_LEN, 3, -1, -1, 1'b1);

    // no eng_done: ch2 frame then wait in DRAIN
    ch_req = 4'b1100;
    run_frame(2, 1'b0, FRAME_LEN, -1, -1, -1, 1'b0);
    ch_req = 4'b1000;
`ifdef CFAR_SCHED_TIMEOUT_EN
    for (int d = 1; d <= TIMEOUT; d++) begin
      tick();
      if (sched_err) err_cnt++;
      if (d == TIMEOUT) check_eq("sched_err_at_timeout", sched_err, 1);
    end
    check_eq("sched_err_once", err_cnt, 1);
    tick();
    check_eq("to_idle_busy", busy, 0);
    check_eq("to_idle_grant", ch_grant, 0);
    check_eq("to_idle_err", sched_err, 0);
    run_frame(3, 1'b0, FRAME_LEN, 1, -1, -1, 1'b1);
`else
    repeat (3 * TIMEOUT) begin
      tick();
      if (!busy) busy_low++;
      if (sched_err) err_cnt++;
    end
    check_eq("busy_hold", busy_low, 0);
    check_eq("no_sched_err", err_cnt, 0);
    check_eq("grant_hold", ch_grant, 4'b0100);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
